// File: rtl/vector_operand_fetch.sv
// Fetches A[i]/B[i] pairs over one shared sync-read memory port; 4-cycle element period (start to first pair: 4 cycles).
// Backpressure: elem_ready low holds the registered pair and suspends all memory requests.
module vector_operand_fetch #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  elem_valid,
    input  logic                  elem_ready,
    output logic [DATA_WIDTH-1:0] elem_a,
    output logic [DATA_WIDTH-1:0] elem_b,
    output logic                  elem_last
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        CAP   = 3'd3,
        VALID = 3'd4
    } state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_a, addr_b;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [DATA_WIDTH-1:0] a_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Memory port is decoded from state and address registers only.
    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        mem_addr = '0;
        case (state)
            IDLE:  if (start && (length != '0)) state_nx = RD_A;
            RD_A: begin
                mem_req  = 1'b1;
                mem_addr = addr_a;
                state_nx = RD_B;
            end
            RD_B: begin
                mem_req  = 1'b1;
                mem_addr = addr_b;
                state_nx = CAP;
            end
            CAP:   state_nx = VALID;
            VALID: if (elem_ready) state_nx = elem_last ? IDLE : RD_A;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_a     <= '0;
            addr_b     <= '0;
            remaining  <= '0;
            a_buf      <= '0;
            elem_a     <= '0;
            elem_b     <= '0;
            elem_valid <= 1'b0;
            elem_last  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            addr_a    <= base_a;
                            addr_b    <= base_b;
                            remaining <= length;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RD_B: a_buf <= mem_rdata;
                CAP: begin
                    elem_a     <= a_buf;
                    elem_b     <= mem_rdata;
                    elem_valid <= 1'b1;
                    elem_last  <= (remaining == LEN_WIDTH'(1));
                    addr_a     <= addr_a + ADDR_WIDTH'(1);
                    addr_b     <= addr_b + ADDR_WIDTH'(1);
                    remaining  <= remaining - LEN_WIDTH'(1);
                end
                VALID: begin
                    if (elem_ready) begin
                        elem_valid <= 1'b0;
                        if (elem_last) done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/vector_operand_fetch.md
# vector_operand_fetch

Upstream feeder for the dot-product engine. On a `start` command it walks two word-addressed vectors, A and B, through one shared synchronous-read data-memory port. It presents each element pair on a valid/ready stream with a last-element flag, so the engine consumes pairs without needing its own memory access logic.

## Interface
- `ADDR_WIDTH`, 12: word-address width of the memory port and of the base addresses.
- `DATA_WIDTH`, 32: element width.
- `LEN_WIDTH`, 8: width of the element count.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_a`  in  ADDR_WIDTH  first word address of vector A; latched on accepted start.
- `base_b`  in  ADDR_WIDTH  first word address of vector B; latched on accepted start.
- `length`  in  LEN_WIDTH  element count, 0..2^LEN_WIDTH-1; latched on accepted start.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `mem_req`  out  1  read request this cycle.
- `mem_addr`  out  ADDR_WIDTH  read address; 0 when `mem_req`=0.
- `mem_rdata`  in  DATA_WIDTH  read data, valid exactly 1 cycle after `mem_req`; the port never stalls.
- `elem_valid`  out  1  `elem_a`/`elem_b`/`elem_last` hold a valid pair.
- `elem_ready`  in  1  consumer accepts the pair.
- `elem_a`  out  DATA_WIDTH  A[i].
- `elem_b`  out  DATA_WIDTH  B[i].
- `elem_last`  out  1  the pair is element length-1.

## Operation
- **State machine:** IDLE, RD_A, RD_B, CAP, VALID.
- **IDLE:**
  - `start`=1 and `length`≠0: latch `addr_a`=`base_a`, `addr_b`=`base_b`, `remaining`=`length`; go to RD_A.
  - `start`=1 and `length`=0: no memory access; `done` pulses next cycle; stay IDLE.
- **RD_A:** `mem_req`=1, `mem_addr`=`addr_a`; go to RD_B.
- **RD_B:** `mem_req`=1, `mem_addr`=`addr_b`; capture `mem_rdata` (A) into `a_buf`; go to CAP.
- **CAP:** `mem_req`=0. On the edge: `elem_a`<=`a_buf`, `elem_b`<=`mem_rdata`, `elem_valid`<=1, `elem_last`<=(`remaining`==1); `addr_a`++, `addr_b`++, `remaining`--; go to VALID.
- **VALID:** hold all outputs stable while `elem_ready`=0; no memory requests.
  - On handshake (`elem_valid`&`elem_ready`), `elem_valid`<=0.
  - If `elem_last`: `done`<=1 for one cycle and go to IDLE.
  - Otherwise go to RD_A.
- **Address wrap:** address increments are modulo 2^ADDR_WIDTH. 0xFFF wraps to 0x000 with no error.
- **`busy`:** 1 in every state except IDLE. It is 0 in the cycle `done` is high.
- **`start` while not IDLE:** ignored; latched operands are unaffected.
- **`mem_req`/`mem_addr`:** decoded combinationally from the state register and address registers only. No combinational path from any input.
- **`elem_*` and `done`:** registered.
- **`rst`:** asserted at any time, including mid-vector, it immediately forces IDLE, clears all registers, and drives every output to 0.
  - No `done` is produced for the aborted command.
  - A new `start` is accepted on the first edge after `rst` deasserts.

## Timing
- **Reset values:** `busy`=0, `done`=0, `mem_req`=0, `mem_addr`=0, `elem_valid`=0, `elem_a`=0, `elem_b`=0, `elem_last`=0.
- **Start to first request:** `start` sampled at edge 0 → RD_A in cycle 1 (first `mem_req`).
- **First element:** `elem_valid` rises at edge 4 (cycle 4 is the first VALID cycle).
- **Element period:** 4 cycles with `elem_ready` held 1. Each cycle of backpressure adds one cycle.
- **Total time:** for N elements with `elem_ready`=1, `done` is high in cycle 4N+1 after the start edge, and `busy` is high in cycles 1..4N.
- **Zero length:** `length`=0 gives `done` in cycle 1 and `busy` never rises.
- **Memory port:** at most one request per cycle, and requests are issued only in RD_A/RD_B.

## Test plan
- **Basic run:**
  - Stimulus: `base_a`=0x010, `base_b`=0x100, `length`=3; memory returns data=address; `elem_ready`=1.
  - Required: `mem_addr` sequence 010,100,011,101,012,102.
  - Required: pairs (0x010,0x100), (0x011,0x101), (0x012,0x102) with `elem_last` only on the third.
  - Required: `done` in cycle 13 only.
- **Backpressure:**
  - Stimulus: same command; `elem_ready`=0 for 5 cycles while the second pair is valid.
  - Required: `elem_a`=0x011 and `elem_b`=0x101 stable; `mem_req`=0 throughout the stall; `done` in cycle 18.
- **Zero length:**
  - Stimulus: `length`=0.
  - Required: `done`=1 for exactly cycle 1; `mem_req`, `elem_valid` and `busy` never assert.
- **Wrap-around:**
  - Stimulus: `base_a`=0xFFF, `base_b`=0x7FF, `length`=2.
  - Required: `mem_addr` sequence FFF,7FF,000,800.
- **Ignored start, then reset:**
  - Stimulus: `start` pulsed with `length`=5 during element 2 of a `length`=4 run.
  - Required: that start is ignored and exactly 4 pairs are produced.
  - Stimulus: rerun, then assert `rst` in an RD_B cycle.
  - Required: all outputs read 0 immediately and no `done` is produced.
- **Maximum length:**
  - Stimulus: `length`=255.
  - Required: 255 handshakes, `elem_last` only on the 255th, `done` in cycle 1021.
